// File: rtl/mbldcm_pkg.sv
// Shared types and constants for the BLDC commutation sequencer.
package mbldcm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [31:0] period_t;

  localparam logic [2:0] PHASE_MAX = 3'd5;

  function automatic logic [2:0] phase_next(input logic [2:0] ph);
    return (ph == PHASE_MAX) ? 3'd0 : ph + 3'd1;
  endfunction

endpackage

// File: rtl/mbldcm_period_ramp.sv
// Saturating one-step move of the live period toward the effective target.
module mbldcm_period_ramp
  import mbldcm_pkg::*;
#(
  parameter period_t pRampStep = 32'd1_000
) (
  input  period_t i_cur,
  input  period_t i_eff,
  output period_t o_next
);

  // 33-bit differences so neither direction can wrap
  logic [32:0] w_dn;
  logic [32:0] w_up;

  assign w_dn = {1'b0, i_cur} - {1'b0, i_eff};
  assign w_up = {1'b0, i_eff} - {1'b0, i_cur};

  always_comb begin
    o_next = i_cur;
    if (i_cur > i_eff)
      o_next = (w_dn > {1'b0, pRampStep}) ? i_cur - pRampStep : i_eff;
    else if (i_cur < i_eff)
      o_next = (w_up > {1'b0, pRampStep}) ? i_cur + pRampStep : i_eff;
  end

endmodule

// File: rtl/mbldcm_commutation_seq.sv
// 6-step commutation sequencer: owns the frequency target, ramps the live
// period toward it and advances the phase once per period.
module mbldcm_commutation_seq
  import mbldcm_pkg::*;
#(
  parameter period_t pStartPeriod = 32'd1_000_000,
  parameter period_t pStopPeriod  = 32'd2_000_000,
  parameter period_t pRampStep    = 32'd1_000,
  parameter period_t pMinPeriod   = 32'd100
) (
  input  logic        iClock,
  input  logic        iReset_n,
  inout  wire  [31:0] ioFreqTarget,
  input  logic        iLatchFreqTarget,
  input  logic [2:0]  iPhaseUpdate,
  input  logic        iLatchPhaseUpdate,
  input  logic        iEnable,
  output logic [2:0]  oPhase,
  output logic        oStep,
  output logic        oFreqReflected,
  output logic        oStop
);

  state_e     r_state, w_state_nxt;
  period_t    r_target, r_cur, r_count;
  period_t    w_cur_nxt, w_count_nxt, w_eff, w_ramp, w_target_in;
  logic [2:0] r_phase, w_phase_nxt;
  logic       r_step, r_refl, r_stop;
  logic       w_step_nxt, w_at_end, w_force;

  // The register interface drives the bus only while strobing a write
  assign ioFreqTarget = iLatchFreqTarget ? 32'bz : r_target;

  assign w_target_in = (ioFreqTarget == '0)        ? '0 :
                       (ioFreqTarget < pMinPeriod) ? pMinPeriod : ioFreqTarget;

  assign w_eff    = (r_target == '0) ? pStopPeriod : r_target;
  assign w_at_end = (r_count == r_cur - 32'd1);
  assign w_force  = iLatchPhaseUpdate && (iPhaseUpdate <= PHASE_MAX);

  mbldcm_period_ramp #(.pRampStep(pRampStep)) u_ramp (
    .i_cur  (r_cur),
    .i_eff  (w_eff),
    .o_next (w_ramp)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    w_step_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (iEnable && r_target != '0) begin
          w_state_nxt = RUN;
          w_cur_nxt   = (r_target > pStartPeriod) ? r_target : pStartPeriod;
        end
      end
      RUN: begin
        if (!iEnable) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (w_at_end) begin
          w_step_nxt  = 1'b1;
          w_phase_nxt = phase_next(r_phase);
          w_count_nxt = '0;
          w_cur_nxt   = w_ramp;
          // stop decision uses the period that just elapsed, not the ramped one
          if (r_target == '0 && r_cur >= pStopPeriod)
            w_state_nxt = IDLE;
        end else begin
          w_count_nxt = r_count + 32'd1;
        end
      end
    endcase
    if (w_force) begin
      w_phase_nxt = iPhaseUpdate;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_cur    <= '0;
      r_count  <= '0;
      r_phase  <= 3'd0;
      r_step   <= 1'b0;
      r_refl   <= 1'b0;
      r_stop   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= w_step_nxt;
      r_stop  <= (w_state_nxt == IDLE);
      r_refl  <= (r_state == RUN) && (r_target != '0) && (r_cur == r_target);
      if (iLatchFreqTarget)
        r_target <= w_target_in;
    end
  end

  assign oPhase         = r_phase;
  assign oStep          = r_step;
  assign oFreqReflected = r_refl;
  assign oStop          = r_stop;

endmodule

// File: tb/tb_mbldcm_commutation_seq.sv
// Bench for mbldcm_commutation_seq: lockstep reference model, a latch/force
// vector table, directed ramp/stop/force sequences and random traffic.
module tb_mbldcm_commutation_seq;

  localparam longint START = 100;
  localparam longint STOP  = 200;
  localparam longint STEP  = 10;
  localparam longint MINP  = 4;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iLatchFreqTarget = 1'b0;
  logic [31:0] tb_val = '0;
  logic [2:0]  iPhaseUpdate = 3'd0;
  logic        iLatchPhaseUpdate = 1'b0;
  logic        iEnable = 1'b0;
  wire  [31:0] ioFreqTarget;
  logic [2:0]  oPhase;
  logic        oStep, oFreqReflected, oStop;

  assign ioFreqTarget = iLatchFreqTarget ? tb_val : 32'bz;

  mbldcm_commutation_seq #(
    .pStartPeriod(32'd100), .pStopPeriod(32'd200),
    .pRampStep(32'd10), .pMinPeriod(32'd4)
  ) dut (
    .iClock(iClock), .iReset_n(iReset_n), .ioFreqTarget(ioFreqTarget),
    .iLatchFreqTarget(iLatchFreqTarget), .iPhaseUpdate(iPhaseUpdate),
    .iLatchPhaseUpdate(iLatchPhaseUpdate), .iEnable(iEnable),
    .oPhase(oPhase), .oStep(oStep), .oFreqReflected(oFreqReflected), .oStop(oStop)
  );

  always #5 iClock = ~iClock;

  int total = 0;
  int bad = 0;

  // reference model state
  longint m_tgt, m_cur, m_cnt;
  int     m_ph;
  bit     m_run, m_step, m_refl;

  function automatic longint floor_tgt(longint v);
    return (v == 0) ? 0 : ((v < MINP) ? MINP : v);
  endfunction

  // move toward eff by at most STEP
  function automatic longint ramp(longint cur, longint eff);
    longint d = eff - cur;
    if (d > STEP) d = STEP;
    if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  task automatic model_reset();
    m_tgt = 0; m_cur = 0; m_cnt = 0; m_ph = 0;
    m_run = 0; m_step = 0; m_refl = 0;
  endtask

  task automatic model_step();
    bit     run0 = m_run;
    longint cur0 = m_cur, cnt0 = m_cnt, tgt0 = m_tgt;
    m_step = 0;
    m_refl = run0 && tgt0 != 0 && cur0 == tgt0;
    if (!run0) begin
      if (iEnable && tgt0 != 0) begin
        m_run = 1; m_cnt = 0;
        m_cur = (tgt0 > START) ? tgt0 : START;
      end
    end else if (!iEnable) begin
      m_run = 0; m_cnt = 0;
    end else if (cnt0 == cur0 - 1) begin
      m_step = 1;
      m_ph = (m_ph + 1) % 6;
      m_cnt = 0;
      m_cur = ramp(cur0, (tgt0 == 0) ? STOP : tgt0);
      if (tgt0 == 0 && cur0 >= STOP) m_run = 0;
    end else begin
      m_cnt = cnt0 + 1;
    end
    if (iLatchPhaseUpdate && iPhaseUpdate <= 3'd5) begin
      m_ph = int'(iPhaseUpdate); m_cnt = 0;
    end
    if (iLatchFreqTarget) m_tgt = floor_tgt(longint'(tb_val));
  endtask

  task automatic check_cycle();
    logic [31:0] rb_exp;
    rb_exp = iLatchFreqTarget ? tb_val : m_tgt[31:0];
    total++;
    if (oPhase !== m_ph[2:0] || oStep !== m_step || oStop !== !m_run ||
        oFreqReflected !== m_refl || ioFreqTarget !== rb_exp) begin
      bad++;
      $display("FAIL model t=%0t got ph=%0d step=%0b stop=%0b refl=%0b bus=%h want ph=%0d step=%0b stop=%0b refl=%0b bus=%h",
               $time, oPhase, oStep, oStop, oFreqReflected, ioFreqTarget,
               m_ph, m_step, !m_run, m_refl, rb_exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    if (!iReset_n) model_reset(); else model_step();
    #1;
    check_cycle();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ticks until oStep is seen; n is the number of clocks taken
  task automatic wait_step(int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!oStep && n < maxc);
    if (!oStep) begin
      total++; bad++;
      $display("FAIL step_timeout got=none want=step within %0d", maxc);
    end
  endtask

  task automatic latch_tgt(logic [31:0] v);
    iLatchFreqTarget = 1'b1; tb_val = v;
    tick();
    iLatchFreqTarget = 1'b0;
  endtask

  task automatic force_ph(logic [2:0] p);
    iLatchPhaseUpdate = 1'b1; iPhaseUpdate = p;
    tick();
    iLatchPhaseUpdate = 1'b0;
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [2:0]  ph;
    logic [31:0] exp_rb;
    logic [2:0]  exp_ph;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n, ph_stop;
    model_reset();
    tbl[0] = '{32'd0,          3'd0, 32'd0,          3'd0};
    tbl[1] = '{32'd2,          3'd3, 32'd4,          3'd3};
    tbl[2] = '{32'd1,          3'd7, 32'd4,          3'd3};
    tbl[3] = '{32'd4,          3'd5, 32'd4,          3'd5};
    tbl[4] = '{32'd5,          3'd6, 32'd5,          3'd5};
    tbl[5] = '{32'd3,          3'd0, 32'd4,          3'd0};
    tbl[6] = '{32'd100,        3'd2, 32'd100,        3'd2};
    tbl[7] = '{32'hFFFF_FFFF,  3'd7, 32'hFFFF_FFFF,  3'd2};

    // 1: reset state
    ticks(2);
    iReset_n = 1'b1;
    ticks(2);
    chk("rst_phase", oPhase, 0);
    chk("rst_stop", oStop, 1);
    chk("rst_refl", oFreqReflected, 0);
    chk("rst_rb", ioFreqTarget, 0);

    // target floor and phase-force table, enable low
    foreach (tbl[i]) begin
      iLatchFreqTarget = 1'b1; tb_val = tbl[i].tgt;
      iLatchPhaseUpdate = 1'b1; iPhaseUpdate = tbl[i].ph;
      tick();
      iLatchFreqTarget = 1'b0; iLatchPhaseUpdate = 1'b0;
      tick();
      chk($sformatf("tbl%0d_rb", i), ioFreqTarget, tbl[i].exp_rb);
      chk($sformatf("tbl%0d_ph", i), oPhase, tbl[i].exp_ph);
      chk($sformatf("tbl%0d_stop", i), oStop, 1);
    end

    // 2: spin-up and ramp down to 50
    force_ph(3'd0);
    latch_tgt(32'd50);
    iEnable = 1'b1;
    tick();
    wait_step(300, n);
    chk("first_period", n, 100);
    chk("first_phase", oPhase, 1);
    for (int i = 1; i <= 5; i++) begin
      wait_step(300, n);
      chk($sformatf("down_period%0d", i), n, 100 - 10 * i);
      chk($sformatf("down_phase%0d", i), oPhase, (i + 1) % 6);
      if (i == 3) chk("refl_before", oFreqReflected, 0);
    end
    chk("refl_at_50", oFreqReflected, 1);

    // 3: target 0 ramps up to the stop period and halts
    latch_tgt(32'd0);
    wait_step(300, n);
    for (int i = 0; i < 15; i++) begin
      wait_step(400, n);
      chk($sformatf("up_period%0d", i), n, 60 + 10 * i);
      chk($sformatf("up_stop%0d", i), oStop, (i == 14) ? 1 : 0);
    end
    ph_stop = int'(oPhase);
    chk("stop_phase", ph_stop, 4);
    ticks(20);
    chk("stop_hold_phase", oPhase, ph_stop);
    chk("stop_hold_stop", oStop, 1);

    // 4: phase force while running
    latch_tgt(32'd50);
    tick();
    ticks(20);
    force_ph(3'd7);
    chk("force7_ignored", oPhase, 4);
    force_ph(3'd3);
    chk("force3", oPhase, 3);
    wait_step(300, n);
    chk("force_restart_period", n, 100);
    chk("force_next_phase", oPhase, 4);
    ticks(89);
    force_ph(3'd3);
    chk("coinc_step", oStep, 1);
    chk("coinc_phase", oPhase, 3);
    wait_step(300, n);
    chk("coinc_ramp_period", n, 80);
    chk("coinc_after_phase", oPhase, 4);

    // 5: drop enable at count 37
    ticks(37);
    iEnable = 1'b0;
    tick();
    chk("drop_stop", oStop, 1);
    chk("drop_nostep", oStep, 0);
    chk("drop_phase", oPhase, 4);
    ticks(10);
    chk("drop_phase_hold", oPhase, 4);

    // 6: huge target ramps up from the start period without overflow
    iEnable = 1'b1;
    latch_tgt(32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      wait_step(300, n);
      chk($sformatf("huge_period%0d", i), n, 100 + 10 * i);
    end
    chk("huge_refl", oFreqReflected, 0);

    // asynchronous reset mid-run
    #3 iReset_n = 1'b0;
    #1;
    chk("arst_phase", oPhase, 0);
    chk("arst_stop", oStop, 1);
    chk("arst_rb", ioFreqTarget, 0);
    model_reset();
    tick();
    iReset_n = 1'b1;
    iEnable = 1'b0;
    tick();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) iEnable = ~iEnable;
      if ($urandom_range(0, 63) == 0) begin
        iLatchFreqTarget = 1'b1;
        case ($urandom_range(0, 3))
          0: tb_val = 32'd0;
          1: tb_val = 32'($urandom_range(1, 6));
          default: tb_val = 32'($urandom_range(7, 250));
        endcase
      end
      if ($urandom_range(0, 39) == 0) begin
        iLatchPhaseUpdate = 1'b1;
        iPhaseUpdate = 3'($urandom_range(0, 7));
      end
      if (c % 500 == 0) iEnable = 1'b1;
      tick();
      iLatchFreqTarget = 1'b0;
      iLatchPhaseUpdate = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbldcm_commutation_seq.md
Name: mbldcm_commutation_seq

Overview:
Commutation sequencer directly downstream of the BLDC Avalon-MM register interface. It owns the frequency-target register on the shared ioFreqTarget bus and ramps the live commutation period toward that target. It advances the 6-step phase (0..5) once per period and returns the status bits (freq reflected, stop) to the register interface.

Parameters:
pStartPeriod, 32'd1_000_000, period in clocks loaded on spin-up
pStopPeriod, 32'd2_000_000, period at or above which a stop request ends rotation
pRampStep, 32'd1_000, maximum period change per commutation step
pMinPeriod, 32'd100, floor applied to the latched target (except 0)

Ports:
iClock  in  1  system clock
iReset_n  in  1  asynchronous active-low reset
ioFreqTarget  inout  32  driven by register I/F on write; this block drives target readback otherwise
iLatchFreqTarget  in  1  write strobe for ioFreqTarget
iPhaseUpdate  in  3  phase value to force
iLatchPhaseUpdate  in  1  phase force strobe
iEnable  in  1  run enable
oPhase  out  3  current commutation phase 0..5
oStep  out  1  one-cycle pulse on each phase advance
oFreqReflected  out  1  live period equals target while running
oStop  out  1  rotation stopped

Behaviour:
- Clock and reset: one clock, iClock. Reset is iReset_n, asynchronous assert, active-low. Reset values: target=0, curPeriod=0, count=0, oPhase=0, oStep=0, oFreqReflected=0, oStop=1, state=IDLE.
- ioFreqTarget: block drives target register when iLatchFreqTarget=0, else Z. No cycle with both drivers active.
- Target latch on iLatchFreqTarget: value 0 stored as 0. Nonzero values below pMinPeriod stored as pMinPeriod. Readback visible the cycle after.
- States: IDLE, RUN.
- IDLE: oStop=1, count held 0, phase held.
  - iEnable=1 and target!=0 -> RUN next clock.
  - On entry to RUN: curPeriod = max(pStartPeriod, target), count=0, oStop=0.
- RUN: count increments each clock.
  - When count==curPeriod-1: oStep=1 the next cycle, phase = (phase==5)?0:phase+1, count=0, curPeriod updates.
  - Effective target eff = (target==0) ? pStopPeriod : target.
  - If cur>eff: cur = (cur-eff > pRampStep) ? cur-pRampStep : eff.
  - If cur<eff: cur = (eff-cur > pRampStep) ? cur+pRampStep : eff.
  - Compare with 33-bit difference; no wrap.
  - Stop: at a step with target==0 and pre-update cur>=pStopPeriod, the phase still advances, then state becomes IDLE and oStop=1.
  - iEnable=0 in RUN -> IDLE next clock, regardless of count. No step is issued.
- oFreqReflected registered: 1 iff state==RUN and curPeriod==target (target!=0).
- Phase force: iLatchPhaseUpdate with iPhaseUpdate<=5 loads phase and clears count, in any state. Values 6 and 7 are ignored entirely.
- Simultaneous events:
  - Phase force and step in the same cycle: the forced value wins; period ramp still applies.
  - New target latched mid-period: takes effect at the next step, and in oFreqReflected the next cycle.
- Reset mid-RUN: immediate return to reset values, including target.

Decomposition:
- Package mbldcm_pkg:
  - state enum (IDLE, RUN)
  - phase constants PHASE_MAX=3'd5
  - 32-bit period type
- Sub-module mbldcm_period_ramp: purely combinational saturating step (cur, eff, pRampStep -> next).

Test Plan:
Bench overrides: pStartPeriod=100, pStopPeriod=200, pRampStep=10, pMinPeriod=4.
1. Reset release, no stimulus -> oPhase=0, oStop=1, oFreqReflected=0, ioFreqTarget reads 0.
2. Latch target 50, set iEnable=1 -> first oStep 100 clocks after RUN entry. Successive periods 100,90,80,70,60,50. oFreqReflected=1 after the step that sets 50. Phase sequence 1,2,3,4,5,0.
3. From steady 50, latch target 0 -> periods 60..200 in steps of 10. The step ending a 200-clock period puts the block in IDLE with oStop=1, and the phase is retained.
4. While running, force phase 7 -> no change. Force phase 3 -> oPhase=3 and count restarts. Force coincident with a step -> oPhase=3.
5. Drop iEnable mid-period at count 37 -> IDLE next clock, no oStep, oStop=1, phase unchanged.
6. Latch target 2 -> readback 4. During the latch cycle the block tri-states (no X on the bus). Latch 0xFFFF_FFFF from cur=100 -> ramps up by 10 with no overflow.
